// File: rtl/multi_tone_gen.sv
// multi_tone_gen: N-channel square-wave tone generator with per-channel note duration
module multi_tone_gen #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 32,
    parameter int DUR_WIDTH = 16,
    parameter int PRESCALE  = 32000,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int MW        = (CHANNELS > 1) ? $clog2(CHANNELS + 1) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [WIDTH-1:0]     wr_period,
    input  logic [DUR_WIDTH-1:0] wr_duration,
    input  logic                 stop_all,
    output logic [CHANNELS-1:0]  tone_out,
    output logic [CHANNELS-1:0]  active,
    output logic [CHANNELS-1:0]  done,
    output logic [MW-1:0]        mix_sum
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {IDLE, PLAYING} state_t;

    state_t               st     [CHANNELS];
    state_t               st_n   [CHANNELS];
    logic [WIDTH-1:0]     per    [CHANNELS];
    logic [WIDTH-1:0]     per_n  [CHANNELS];
    logic [WIDTH-1:0]     cnt    [CHANNELS];
    logic [WIDTH-1:0]     cnt_n  [CHANNELS];
    logic [DUR_WIDTH-1:0] dur    [CHANNELS];
    logic [DUR_WIDTH-1:0] dur_n  [CHANNELS];
    logic [CHANNELS-1:0]  tone, tone_n, done_n;
    logic [PW-1:0]        pre;
    logic                 tick;

    assign tick = (pre == PW'(PRESCALE - 1));

    // free-running duration prescaler, never resynchronised by writes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pre <= '0;
        else     pre <= tick ? '0 : pre + 1'b1;
    end

    // next-state for every channel: stop_all > write > expiry > tone counting
    always_comb begin
        tone_n = tone;
        done_n = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            st_n[c]  = st[c];
            per_n[c] = per[c];
            cnt_n[c] = cnt[c];
            dur_n[c] = dur[c];
            if (stop_all) begin
                st_n[c]   = IDLE;
                cnt_n[c]  = '0;
                tone_n[c] = 1'b0;
            end else if (wr_en && wr_ch == CH_W'(c)) begin
                st_n[c]   = (wr_period != '0) ? PLAYING : IDLE;
                per_n[c]  = (wr_period != '0) ? wr_period : per[c];
                dur_n[c]  = (wr_period != '0) ? wr_duration : dur[c];
                cnt_n[c]  = '0;
                tone_n[c] = 1'b0;
            end else if (st[c] == PLAYING) begin
                if (tick && dur[c] == DUR_WIDTH'(1)) begin
                    st_n[c]   = IDLE;
                    cnt_n[c]  = '0;
                    tone_n[c] = 1'b0;
                    done_n[c] = 1'b1;
                end else begin
                    dur_n[c]  = (tick && dur[c] != '0) ? dur[c] - 1'b1 : dur[c];
                    cnt_n[c]  = (cnt[c] == per[c] - WIDTH'(1)) ? '0 : cnt[c] + 1'b1;
                    tone_n[c] = (cnt[c] == per[c] - WIDTH'(1)) ? ~tone[c] : tone[c];
                end
            end
        end
    end

    // channel state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tone <= '0;
            done <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                st[c]  <= IDLE;
                per[c] <= '0;
                cnt[c] <= '0;
                dur[c] <= '0;
            end
        end else begin
            tone <= tone_n;
            done <= done_n;
            for (int c = 0; c < CHANNELS; c++) begin
                st[c]  <= st_n[c];
                per[c] <= per_n[c];
                cnt[c] <= cnt_n[c];
                dur[c] <= dur_n[c];
            end
        end
    end

    // outputs and popcount of the registered tones
    always_comb begin
        tone_out = tone;
        mix_sum  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            active[c] = (st[c] == PLAYING);
            mix_sum   = mix_sum + MW'(tone[c]);
        end
    end
endmodule
